// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module : mem_arb_pkg
// Brief  : Shared encodings and default sizing for the memory port arbiter.
// Rev    : 1.0  initial release
// ============================================================================
package mem_arb_pkg;

  localparam int DEF_ADDR_W  = 32;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_TIMEOUT = 16;

  // Wide enough for the largest legal TIMEOUT (255)
  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_RESP   = 2'b10
  } state_t;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_D  = 1'b1;

endpackage
`default_nettype wire

// File: rtl/arb_rr2.sv
`default_nettype none
// ============================================================================
// Module : arb_rr2
// Brief  : Two-request round-robin picker; bit 0 = fetch, bit 1 = data.
// Rev    : 1.0  initial release
// ============================================================================
module arb_rr2 (
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = 2'b00;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      // On conflict, favour whichever side did not win last time
      2'b11:   gnt_o = last_i ? 2'b01 : 2'b10;
      default: gnt_o = 2'b00;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module : mem_port_arbiter
// Brief  : Shares one memory port between fetch and data requesters with
//          round-robin arbitration, one outstanding access and a timeout.
// Rev    : 1.0  initial release
// ============================================================================
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              RST,
  // fetch requester
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  output logic              if_err,
  // data requester
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_valid,
  output logic              d_err,
  // memory side
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              busy
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t             state_q;
  logic               owner_q;
  logic               last_gnt_q;
  logic               we_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  wdata_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [DATA_W-1:0]  if_rdata_q;
  logic [DATA_W-1:0]  d_rdata_q;
  logic               if_err_q;
  logic               d_err_q;
  logic               if_valid_q;
  logic               d_valid_q;

  logic [1:0]         pick;
  logic               idle_ok;
  logic               access_done;
  logic [DATA_W-1:0]  rsp_rdata_d;
  logic               rsp_err_d;

  arb_rr2 u_rr (
    .req_i  ({d_req, if_req}),
    .last_i (last_gnt_q),
    .gnt_o  (pick)
  );

  // Grants are combinational so a requester sees gnt in its request cycle
  assign idle_ok = (state_q == ST_IDLE) && !RST;
  assign if_gnt  = pick[0] && idle_ok;
  assign d_gnt   = pick[1] && idle_ok;

  // mem_ready beats counter expiry when both land in the same cycle
  assign access_done = mem_ready || (cnt_q == CNT_LAST);
  assign rsp_rdata_d = (mem_ready && !we_q) ? mem_rdata : '0;
  assign rsp_err_d   = !mem_ready;

  always_ff @(posedge clk) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      owner_q    <= OWN_IF;
      last_gnt_q <= OWN_D;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      cnt_q      <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
      if_err_q   <= 1'b0;
      d_err_q    <= 1'b0;
      if_valid_q <= 1'b0;
      d_valid_q  <= 1'b0;
    end else begin
      if_valid_q <= 1'b0;
      d_valid_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (if_gnt || d_gnt) begin
            owner_q    <= d_gnt ? OWN_D : OWN_IF;
            last_gnt_q <= d_gnt ? OWN_D : OWN_IF;
            we_q       <= d_gnt && d_we;
            addr_q     <= d_gnt ? d_addr : if_addr;
            wdata_q    <= d_gnt ? d_wdata : '0;
            cnt_q      <= '0;
            state_q    <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (access_done) begin
            if (owner_q == OWN_D) begin
              d_rdata_q <= rsp_rdata_d;
              d_err_q   <= rsp_err_d;
              d_valid_q <= 1'b1;
            end else begin
              if_rdata_q <= rsp_rdata_d;
              if_err_q   <= rsp_err_d;
              if_valid_q <= 1'b1;
            end
            state_q <= ST_RESP;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_RESP: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign mem_en    = (state_q == ST_ACCESS) && !RST;
  assign mem_we    = mem_en && we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = (state_q != ST_IDLE) && !RST;

  assign if_rdata  = if_rdata_q;
  assign if_err    = if_err_q;
  assign if_valid  = if_valid_q;
  assign d_rdata   = d_rdata_q;
  assign d_err     = d_err_q;
  assign d_valid   = d_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_mem_port_arbiter
// Brief  : Transaction-level reference model and directed/random scenarios.
// Rev    : 1.0  initial release
// ============================================================================
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          RST;
  logic          if_req, d_req, d_we, mem_ready;
  logic [AW-1:0] if_addr, d_addr;
  logic [DW-1:0] d_wdata, mem_rdata;
  logic          if_gnt, if_valid, if_err, d_gnt, d_valid, d_err;
  logic          mem_en, mem_we, busy;
  logic [DW-1:0] if_rdata, d_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;

  int checks = 0;
  int errors = 0;

  // Model state: who won last conflict, and each requester's held response
  logic          m_last;
  logic [DW-1:0] m_rd [2];
  logic          m_err[2];

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .RST(RST),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rdata(if_rdata),
    .if_valid(if_valid), .if_err(if_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rdata(d_rdata), .d_valid(d_valid), .d_err(d_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .busy(busy)
  );

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_last   = 1'b1;
    m_rd[0]  = '0;
    m_rd[1]  = '0;
    m_err[0] = 1'b0;
    m_err[1] = 1'b0;
  endtask

  // One full transaction starting in an IDLE cycle; delay = not-ready cycles before mem_ready
  task automatic run_txn(input logic ireq, input logic dreq, input logic dwe,
                         input logic [AW-1:0] ia, input logic [AW-1:0] da,
                         input logic [DW-1:0] wd, input int delay,
                         input logic [DW-1:0] rdv);
    logic          own;
    int            n_acc;
    logic          exp_err;
    logic [DW-1:0] exp_rd;
    logic [AW-1:0] exp_addr;
    logic [6:0]    obs, exp;
    own      = (ireq && dreq) ? !m_last : dreq;
    n_acc    = (delay < TO) ? delay + 1 : TO;
    exp_err  = (delay >= TO);
    exp_rd   = (exp_err || (own && dwe)) ? '0 : rdv;
    exp_addr = own ? da : ia;

    if_req = ireq; d_req = dreq; d_we = dwe; if_addr = ia; d_addr = da;
    d_wdata = wd; mem_ready = 1'($urandom); mem_rdata = $urandom;
    #1;
    obs = {if_gnt, d_gnt, busy, mem_en, mem_we, if_valid, d_valid};
    exp = {!own, own, 5'b0};
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL idle_ctrl t=%0t: got %b expected %b", $time, obs, exp);
    end
    checks++;
    if ({if_rdata, d_rdata, if_err, d_err} !== {m_rd[0], m_rd[1], m_err[0], m_err[1]}) begin
      errors++;
      $display("FAIL idle_hold t=%0t: got %h/%h err %b%b expected %h/%h err %b%b", $time,
               if_rdata, d_rdata, if_err, d_err, m_rd[0], m_rd[1], m_err[0], m_err[1]);
    end
    next_cycle();

    for (int j = 0; j < n_acc; j++) begin
      if_req = 1'($urandom); d_req = 1'($urandom); d_we = 1'($urandom);
      if_addr = $urandom; d_addr = $urandom; d_wdata = $urandom;
      mem_ready = (j == delay);
      mem_rdata = (j == delay) ? rdv : $urandom;
      #1;
      obs = {mem_en, mem_we, busy, if_gnt, d_gnt, if_valid, d_valid};
      exp = {1'b1, own && dwe, 1'b1, 4'b0};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL access_ctrl cyc=%0d t=%0t: got %b expected %b", j, $time, obs, exp);
      end
      checks++;
      if (mem_addr !== exp_addr || (own && mem_wdata !== wd)) begin
        errors++;
        $display("FAIL access_bus cyc=%0d: got addr %h wdata %h expected addr %h wdata %h",
                 j, mem_addr, mem_wdata, exp_addr, wd);
      end
      next_cycle();
    end

    m_rd[own]  = exp_rd;
    m_err[own] = exp_err;
    m_last     = own;
    if_req = 1'($urandom); d_req = 1'($urandom);
    mem_ready = 1'($urandom); mem_rdata = $urandom;
    #1;
    obs = {mem_en, mem_we, busy, if_gnt, d_gnt, if_valid, d_valid};
    exp = {3'b001, 2'b00, !own, own};
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL resp_ctrl t=%0t: got %b expected %b", $time, obs, exp);
    end
    checks++;
    if ({if_rdata, d_rdata, if_err, d_err} !== {m_rd[0], m_rd[1], m_err[0], m_err[1]}) begin
      errors++;
      $display("FAIL resp_data t=%0t: got %h/%h err %b%b expected %h/%h err %b%b", $time,
               if_rdata, d_rdata, if_err, d_err, m_rd[0], m_rd[1], m_err[0], m_err[1]);
    end
    next_cycle();
  endtask

  task automatic test_reset();
    RST = 1'b1; if_req = 1'b1; d_req = 1'b1; d_we = 1'b1; mem_ready = 1'b1;
    if_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '1;
    next_cycle();
    next_cycle();
    checks++;
    if ({if_gnt, d_gnt, mem_en, mem_we, busy, if_valid, d_valid, if_err, d_err} !== 9'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 000000000",
               {if_gnt, d_gnt, mem_en, mem_we, busy, if_valid, d_valid, if_err, d_err});
    end
    checks++;
    if ({if_rdata, d_rdata} !== '0) begin
      errors++;
      $display("FAIL reset_rdata: got %h/%h expected 0/0", if_rdata, d_rdata);
    end
    RST = 1'b0; if_req = 1'b0; d_req = 1'b0;
    model_reset();
    next_cycle();
  endtask

  task automatic test_fetch_only();
    run_txn(1'b1, 1'b0, 1'b0, 32'h40, 32'h0, 32'h0, 0, 32'h1234_5678);
  endtask

  task automatic test_conflict();
    test_reset();
    for (int k = 0; k < 3; k++)
      run_txn(1'b1, 1'b1, 1'b0, $urandom, $urandom, $urandom, 0, $urandom);
  endtask

  task automatic test_write();
    run_txn(1'b0, 1'b1, 1'b1, 32'h0, 32'h100, 32'hDEAD_BEEF, 3, $urandom);
  endtask

  task automatic test_timeout();
    run_txn(1'b0, 1'b1, 1'b0, 32'h0, 32'h200, 32'h0, 1000, 32'hCAFE_F00D);
    run_txn(1'b0, 1'b1, 1'b0, 32'h0, 32'h204, 32'h0, 1, 32'h0BAD_C0DE);
  endtask

  task automatic test_coincide();
    run_txn(1'b1, 1'b0, 1'b0, 32'h300, 32'h0, 32'h0, TO - 1, 32'h5555_AAAA);
    run_txn(1'b1, 1'b0, 1'b0, 32'h304, 32'h0, 32'h0, TO, 32'h7777_1111);
  endtask

  task automatic test_reset_mid();
    if_req = 1'b0; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h400; mem_ready = 1'b0;
    #1;
    checks++;
    if ({if_gnt, d_gnt} !== 2'b01) begin
      errors++;
      $display("FAIL rstmid_gnt: got %b expected 01", {if_gnt, d_gnt});
    end
    next_cycle();
    d_req = 1'b0;
    next_cycle();
    RST = 1'b1;
    #1;
    checks++;
    if ({mem_en, mem_we, busy, if_gnt, d_gnt} !== 5'b0) begin
      errors++;
      $display("FAIL rstmid_same: got %b expected 00000", {mem_en, mem_we, busy, if_gnt, d_gnt});
    end
    next_cycle();
    RST = 1'b0; mem_ready = 1'b1;
    model_reset();
    for (int k = 0; k < 2; k++) begin
      #1;
      checks++;
      if ({mem_en, busy, if_valid, d_valid, if_err, d_err} !== 6'b0 || {if_rdata, d_rdata} !== '0) begin
        errors++;
        $display("FAIL rstmid_after k=%0d: got ctrl %b rdata %h/%h expected 000000 0/0",
                 k, {mem_en, busy, if_valid, d_valid, if_err, d_err}, if_rdata, d_rdata);
      end
      next_cycle();
    end
    run_txn(1'b1, 1'b1, 1'b0, 32'h500, 32'h504, 32'h0, 0, 32'h1357_9BDF);
  endtask

  task automatic test_random();
    logic ir, dr;
    int   dly;
    for (int n = 0; n < 40; n++) begin
      ir  = 1'($urandom);
      dr  = 1'($urandom);
      if (!ir && !dr) ir = 1'b1;
      dly = ($urandom_range(0, 3) == 0) ? $urandom_range(TO - 2, TO + 2) : $urandom_range(0, 4);
      run_txn(ir, dr, 1'($urandom), $urandom, $urandom, $urandom, dly, $urandom);
    end
  endtask

  initial begin
    test_reset();
    test_fetch_only();
    test_conflict();
    test_write();
    test_timeout();
    test_coincide();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width.
REQ-003 SHALL have parameter TIMEOUT, default 16, maximum ACCESS cycles before abort (legal range 2..255).
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port RST, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have fetch ports: if_req in 1; if_addr in ADDR_W; if_gnt out 1; if_rdata out DATA_W; if_valid out 1; if_err out 1.
REQ-007 SHALL have data ports: d_req in 1; d_we in 1; d_addr in ADDR_W; d_wdata in DATA_W; d_gnt out 1; d_rdata out DATA_W; d_valid out 1; d_err out 1.
REQ-008 SHALL have memory ports: mem_en out 1; mem_we out 1; mem_addr out ADDR_W; mem_wdata out DATA_W; mem_rdata in DATA_W; mem_ready in 1.
REQ-009 SHALL have port busy, output, 1 bit: high whenever state is not IDLE.

Function
REQ-010 SHALL implement the states IDLE, ACCESS and RESP, with one transaction outstanding at a time.
REQ-011 In IDLE, a requester SHALL hold req, addr, we and wdata stable until its gnt is asserted.
REQ-012 In IDLE, gnt SHALL be combinational: x_gnt = x_req AND selected(x) AND (state==IDLE), with at most one gnt high in any cycle.
REQ-013 When only one requester has req high, the arbiter SHALL select that requester.
REQ-014 When both requesters have req high in the same cycle, the arbiter SHALL select the requester that was not the last granted (round-robin), using the 1-bit last_gnt register.
REQ-015 On gnt, the arbiter SHALL register owner, address, we (forced to 0 for fetch) and wdata, update last_gnt, clear the timeout counter, and enter ACCESS on the next cycle.
REQ-016 In ACCESS, mem_en SHALL be 1 and mem_addr, mem_we and mem_wdata SHALL drive the registered values, held stable until exit.
REQ-017 In ACCESS with mem_ready=1, the arbiter SHALL capture mem_rdata (reads; 0 for writes) into the owner's rdata register, clear err, and enter RESP.
REQ-018 In ACCESS with mem_ready=0, the arbiter SHALL increment the counter; when the counter reaches TIMEOUT-1 without mem_ready, it SHALL set the owner's err, zero the owner's rdata, and enter RESP.
REQ-019 If mem_ready and counter expiry coincide, mem_ready SHALL win and err SHALL be 0.
REQ-020 In RESP, the owner's valid SHALL be 1 for exactly one cycle, mem_en SHALL be 0, and the next state SHALL be IDLE.
REQ-021 No gnt SHALL be issued in RESP.
REQ-022 Completion of a write SHALL also pulse d_valid.
REQ-023 rdata and err SHALL hold their value until the next completion for the same requester.
REQ-024 Minimum latency SHALL be: gnt at cycle 0, mem_en at cycle 1, mem_ready earliest at cycle 1, valid at cycle 2, next gnt at cycle 3.
REQ-025 Outside ACCESS, mem_en and mem_we SHALL be 0.
REQ-026 mem_ready SHALL be ignored outside ACCESS.

Reset
REQ-027 While RST=1 at a clock edge, the arbiter SHALL force state=IDLE, last_gnt=DATA (so fetch wins the first conflict), counter=0, all rdata=0, all err=0, and all valid=0.
REQ-028 While RST=1, gnt, mem_en, mem_we and busy SHALL be 0 in the same cycle.
REQ-029 A reset asserted in ACCESS or RESP SHALL abort the transaction with no valid pulse.

Structure
REQ-030 Package mem_arb_pkg SHALL hold the state encoding (IDLE=2'b00, ACCESS=2'b01, RESP=2'b10), the owner encoding (OWN_IF=0, OWN_D=1) and the default widths/TIMEOUT constants.
REQ-031 The design SHALL contain one sub-module, arb_rr2: a 2-request round-robin picker with inputs req[1:0] and last, and a one-hot grant output.

Verification
REQ-032 Fetch only: if_req=1, if_addr=0x40, mem_ready=1 at the first ACCESS cycle, mem_rdata=0x1234_5678 -> if_gnt at cycle 0, mem_en at cycle 1, if_valid at cycle 2 with if_rdata=0x12345678.
REQ-033 Conflict after reset: both req=1 -> if_gnt first; keep both req=1 -> next gnt is d_gnt; then if_gnt again (strict alternation).
REQ-034 Data write: d_we=1, d_addr=0x100, d_wdata=0xDEADBEEF, mem_ready delayed 3 cycles -> mem_we=1, addr/wdata held 4 ACCESS cycles, d_valid pulses once, d_rdata=0.
REQ-035 Timeout: TIMEOUT=16, mem_ready=0 -> mem_en high exactly 16 cycles, then d_valid=1 with d_err=1; a subsequent good access clears d_err.
REQ-036 Reset mid-ACCESS: RST=1 on the 2nd ACCESS cycle -> next cycle mem_en=0, busy=0, no valid pulse, and the next conflict grants fetch.
REQ-037 Coincidence: mem_ready=1 on the expiry cycle -> valid=1, err=0, rdata=mem_rdata.
